// File: rtl/arm_mem_defs.sv
// Shared definitions for the MEM-stage data memory path.
// Used by the SRAM controller and by the data-memory model.
package arm_mem_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    localparam int unsigned SRAM_DW       = 16;
    localparam int unsigned SRAM_ADDR_W   = 18;
    localparam int unsigned MEM_BASE_ADDR = 1024;

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage request/response bundle between the pipeline and the SRAM controller.
interface sram_controller_if;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/wait_counter.sv
// Per-phase wait counter: counts 0..WAIT_CYCLES-1, flags the final cycle of a phase.
module wait_counter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o,
    output logic last_next_o
);

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = 4'd0;
        else if (en_i)
            count_d = count_q + 4'd1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= 4'd0;
        else
            count_q <= count_d;
    end

    assign last_o      = (count_q == LAST);
    // Lets the pin registers know one cycle ahead which cycle is the release cycle.
    assign last_next_o = (count_d == LAST);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage responder: splits each 32-bit access into two 16-bit asynchronous SRAM
// accesses (low half first) and holds ready low while the access is in flight.
module sram_controller
    import arm_mem_defs::*;
#(
    parameter int unsigned BASE_ADDR   = MEM_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_AW     = SRAM_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam bit SINGLE_CYCLE = (WAIT_CYCLES == 1);

    mem_state_e state_q, state_d;

    logic               req;
    logic [31:0]        eff;
    logic               is_wr_q, is_wr_sel;
    logic [SRAM_AW-2:0] row_q, row_sel;
    logic [31:0]        wdata_q, wdata_sel;
    logic [31:0]        read_data_q, read_data_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic               oe_q, oe_d;
    logic               we_n_q, we_n_d;
    logic               phase_q, phase_d;
    logic               last, last_next;
    logic               unused_eff_bits;

    assign req = bus.rd_en | bus.wr_en;
    assign eff = bus.address - 32'(BASE_ADDR);
    assign unused_eff_bits = ^{eff[31:SRAM_AW+1], eff[1:0]};

    // The pin registers are loaded on the IDLE->LO edge, before the request is latched.
    assign is_wr_sel = (state_q == IDLE) ? bus.wr_en : is_wr_q;
    assign row_sel   = (state_q == IDLE) ? eff[SRAM_AW:2] : row_q;
    assign wdata_sel = (state_q == IDLE) ? bus.write_data : wdata_q;

    assign phase_q = (state_q == LO) || (state_q == HI);
    assign phase_d = (state_d == LO) || (state_d == HI);

    wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (state_d != state_q),
        .en_i        (phase_q),
        .last_o      (last),
        .last_next_o (last_next)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req) state_d = LO;
            LO:   if (!req) state_d = IDLE; else if (last) state_d = HI;
            HI:   if (!req) state_d = IDLE; else if (last) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        read_data_d = read_data_q;
        addr_d      = addr_q;
        dq_out_d    = dq_out_q;
        oe_d        = 1'b0;
        we_n_d      = 1'b1;

        if (req && last && !is_wr_q) begin
            if (state_q == LO) read_data_d[15:0]  = sram_dq_in;
            if (state_q == HI) read_data_d[31:16] = sram_dq_in;
        end

        if (phase_d) begin
            addr_d = {row_sel, (state_d == HI)};
            if (is_wr_sel) begin
                oe_d     = 1'b1;
                dq_out_d = (state_d == HI) ? wdata_sel[31:16] : wdata_sel[15:0];
                // The last cycle of each phase releases we_n for setup/hold.
                we_n_d   = last_next && !SINGLE_CYCLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            row_q       <= '0;
            wdata_q     <= '0;
            read_data_q <= '0;
            addr_q      <= '0;
            dq_out_q    <= '0;
            oe_q        <= 1'b0;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            read_data_q <= read_data_d;
            addr_q      <= addr_d;
            dq_out_q    <= dq_out_d;
            oe_q        <= oe_d;
            we_n_q      <= we_n_d;
            if (state_q == IDLE && req) begin
                is_wr_q <= bus.wr_en;
                row_q   <= eff[SRAM_AW:2];
                wdata_q <= bus.write_data;
            end
        end
    end

    assign bus.ready     = ~req | (state_q == DONE);
    assign bus.read_data = read_data_q;
    assign sram_addr     = addr_q;
    assign sram_dq_out   = dq_out_q;
    assign sram_dq_oe    = oe_q;
    assign sram_we_n     = we_n_q;

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Memory-side responder for the ARM pipeline's MEM stage: takes the stage's read/write requests and answers them from an external 16-bit asynchronous SRAM.
- Each 32-bit data word is split into two 16-bit SRAM accesses, low half first.
- While an access is in flight, the block holds ready low; the hazard/freeze logic uses ready to stall the whole pipeline.
- Sits between the EXE/MEM pipeline register and the board SRAM pins.

Parameters:
- BASE_ADDR, 1024: data-memory base address; subtracted from the CPU address before mapping.
- WAIT_CYCLES, 2: clock cycles each 16-bit SRAM access is held; legal range 1..15.
- SRAM_AW, 18: SRAM address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_en  in  1  MEM stage read request (MEM_R_EN), held high until ready.
- wr_en  in  1  MEM stage write request (MEM_W_EN), held high until ready.
- address  in  32  byte address from the ALU result; word aligned.
- write_data  in  32  store data (Val_Rm).
- read_data  out  32  load result; holds its value until the next read completes.
- ready  out  1  high when no request is pending, or the pending access is completing.
- sram_addr  out  SRAM_AW  SRAM half-word address.
- sram_dq_out  out  16  write data driven toward the SRAM pins.
- sram_dq_in  in  16  read data from the SRAM pins.
- sram_dq_oe  out  1  1 = controller drives the DQ bus (writes only).
- sram_we_n  out  1  SRAM write enable, active low.

Behaviour:
- Reset values (async, rst=1): state IDLE, counter 0, read_data 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1.
- ready is combinational: ~(rd_en | wr_en) | (state == DONE). After reset with no request, ready = 1.
- Address map: eff = address - BASE_ADDR (32-bit wrap). Low half: sram_addr = {eff[18:2], 1'b0}. High half: sram_addr = {eff[18:2], 1'b1}. eff[1:0] is ignored.
- States and transitions:
  - IDLE -> LO when rd_en | wr_en. The operation and the address are latched at that edge. If both enables are high, the access is a write.
  - LO: drive the low-half address for WAIT_CYCLES cycles. On the last LO cycle, a read captures sram_dq_in into read_data[15:0]. Then LO -> HI.
  - HI: same as LO for the high half; a read captures into read_data[31:16] on the last HI cycle. Then HI -> DONE.
  - DONE: lasts 1 cycle with ready = 1. DONE -> IDLE unconditionally; a request still high in the following cycle starts a new access.
- Writes:
  - sram_dq_oe = 1 in LO and HI.
  - sram_dq_out = latched write_data[15:0] in LO, [31:16] in HI.
  - sram_we_n = 0 on every LO/HI cycle except the last cycle of each phase, which is the setup/hold release cycle. When WAIT_CYCLES = 1, sram_we_n is 0 for the single cycle.
- Reads: sram_we_n = 1 and sram_dq_oe = 0 throughout.
- Latency: the request is seen in cycle 0 (IDLE), and ready goes high in cycle 2*WAIT_CYCLES + 1. With the default, that is cycle 5, so ready is low for 5 cycles.
- Request dropped in LO/HI (protocol violation): the block returns to IDLE at the next edge, never reaches DONE, and read_data is not fully updated. A write may be partially done; this is not recovered.
- rst asserted mid-access: the block goes to IDLE immediately with sram_we_n = 1 and sram_dq_oe = 0. A partial write may remain in the SRAM.
- The counter counts 0..WAIT_CYCLES-1 within a phase, clears on each phase change, and never wraps inside a phase.

Decomposition:
- Shared package (arm_mem_defs):
  - State encoding: IDLE = 0, LO = 1, HI = 2, DONE = 3, 2 bits.
  - SRAM data width 16 and address width 18.
  - BASE_ADDR constant, which the data-memory model also uses.
- One natural sub-module: wait_counter. It is a 4-bit counter with clear and enable, plus a last output for count == WAIT_CYCLES-1.

Test Plan:
- Reset, then idle with no request -> ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0.
- Write: wr_en=1, address=1024, write_data=0xDEADBEEF -> ready low for cycles 0-4. sram_addr=0 with dq 0xBEEF, then sram_addr=1 with dq 0xDEAD. sram_we_n low 1 cycle per half. ready=1 in cycle 5.
- Read back: rd_en=1, address=1024, SRAM model returns 0xBEEF/0xDEAD -> read_data=0xDEADBEEF in the DONE cycle, held after rd_en drops.
- Address map: address=1024+4*5 -> sram_addr 10 then 11. Also rd_en=wr_en=1 at once -> executes as a write.
- Back-to-back: rd_en held through DONE -> a second access starts with ready=0 on the next cycle; two 6-cycle transactions are seen.
- rst pulsed in the HI phase of a write -> sram_we_n=1 and sram_dq_oe=0 in the same cycle, state IDLE, ready follows the request rule.
